// File: rtl/nx1_pkg.sv
// Shared definitions for the X1 graphic VRAM access sequencer.
package nx1_pkg;

  // VRAM plane codes, the top two bits of the VRAM address
  localparam logic [1:0] PL_B = 2'd1;
  localparam logic [1:0] PL_R = 2'd2;
  localparam logic [1:0] PL_G = 2'd3;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, HOLD} state_e;

  // In DAM mode the addressed plane is skipped and the other two are written.
  // Result is {first, second}; sel=0 never starts a sequence.
  function automatic logic [3:0] dam_pair(input logic [1:0] sel);
    logic [3:0] pair;
    case (sel)
      2'd1:    pair = {PL_R, PL_G};
      2'd2:    pair = {PL_B, PL_G};
      2'd3:    pair = {PL_B, PL_R};
      default: pair = 4'd0;
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/nx1_gram_dam.sv
// Graphic VRAM access sequencer: turns CPU I/O cycles to 0x4000-0xFFFF into
// one plane access, or two plane writes when DAM mode is active.
module nx1_gram_dam
  import nx1_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic          C_CLK,
  input  logic          I_RESET_n,
  input  logic [15:0]   I_A,
  input  logic [7:0]    I_D,
  input  logic          I_WR,
  input  logic          I_RD,
  input  logic          I_GRAM_CS,
  input  logic          I_DAM,
  output logic          O_WAIT,
  output logic [7:0]    O_DQ,
  output logic [AW+1:0] O_VA,
  output logic [7:0]    O_VD,
  output logic          O_VREQ,
  output logic          O_VWE,
  input  logic          I_VACK,
  input  logic [7:0]    I_VQ
);

  state_e        state;
  logic          strb_q;
  logic          wait_q;
  logic          we_q;
  logic          dam_q;
  logic [1:0]    sec_q;
  logic [AW-1:0] off_q;

  logic          strb;
  logic          start;
  logic [1:0]    sel;
  logic [3:0]    pair;
  logic [1:0]    first_pl;

  // Start detection and first-plane selection from the live CPU cycle
  always_comb begin
    sel      = I_A[15:14];
    pair     = dam_pair(sel);
    strb     = (I_WR | I_RD) & I_GRAM_CS;
    start    = strb & ~strb_q & (sel != 2'd0) & (state == IDLE);
    first_pl = (I_WR && I_DAM) ? pair[3:2] : sel;
  end

  // Wait is raised combinationally in the start cycle so the CPU is held
  // before the registered request appears; reset forces it low.
  assign O_WAIT = wait_q | (start & I_RESET_n);

  // Sequencer FSM with registered VRAM bus and read-data capture
  always_ff @(posedge C_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state  <= IDLE;
      strb_q <= 1'b0;
      wait_q <= 1'b0;
      we_q   <= 1'b0;
      dam_q  <= 1'b0;
      sec_q  <= 2'd0;
      off_q  <= '0;
      O_DQ   <= 8'd0;
      O_VA   <= '0;
      O_VD   <= 8'd0;
      O_VREQ <= 1'b0;
      O_VWE  <= 1'b0;
    end else begin
      strb_q <= strb;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= ACC1;
            wait_q <= 1'b1;
            we_q   <= I_WR;
            dam_q  <= I_DAM;
            sec_q  <= pair[1:0];
            off_q  <= I_A[AW-1:0];
            O_VA   <= {first_pl, I_A[AW-1:0]};
            O_VD   <= I_D;
            O_VREQ <= 1'b1;
            O_VWE  <= I_WR;
          end
        end
        ACC1: begin
          if (I_VACK) begin
            if (we_q && dam_q) begin
              // Back-to-back second write, no idle gap on the bus
              state <= ACC2;
              O_VA  <= {sec_q, off_q};
            end else begin
              state  <= HOLD;
              wait_q <= 1'b0;
              O_VREQ <= 1'b0;
              O_VWE  <= 1'b0;
              if (!we_q) begin
                O_DQ <= I_VQ;
              end
            end
          end
        end
        ACC2: begin
          if (I_VACK) begin
            state  <= HOLD;
            wait_q <= 1'b0;
            O_VREQ <= 1'b0;
            O_VWE  <= 1'b0;
          end
        end
        HOLD: begin
          // Strobe must drop before a new cycle can be recognised
          if (!I_WR && !I_RD) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nx1_gram_dam.sv
// Directed self-checking bench for nx1_gram_dam with a small VRAM responder.
module tb_nx1_gram_dam;
  import nx1_pkg::*;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   a;
  logic [7:0]    d;
  logic          wr, rd, gram_cs, dam;
  logic          wait_o;
  logic [7:0]    dq;
  logic [AW+1:0] va;
  logic [7:0]    vd;
  logic          vreq, vwe;
  logic          vack;
  logic [7:0]    vq;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder configuration and access log
  int          ack_delay = 0;
  logic [7:0]  vq_val = 8'h00;
  int          req_age = 0;
  int          n_acc = 0;
  int          wait_cnt = 0;
  int          vreq_cnt = 0;
  logic [15:0] log_va [64];
  logic [7:0]  log_vd [64];
  logic        log_we [64];

  nx1_gram_dam #(.AW(AW)) dut (
    .C_CLK     (clk),
    .I_RESET_n (rst_n),
    .I_A       (a),
    .I_D       (d),
    .I_WR      (wr),
    .I_RD      (rd),
    .I_GRAM_CS (gram_cs),
    .I_DAM     (dam),
    .O_WAIT    (wait_o),
    .O_DQ      (dq),
    .O_VA      (va),
    .O_VD      (vd),
    .O_VREQ    (vreq),
    .O_VWE     (vwe),
    .I_VACK    (vack),
    .I_VQ      (vq)
  );

  always #5 clk = ~clk;

  // VRAM model: acknowledges after ack_delay extra request cycles
  always @(negedge clk) begin
    if (wait_o) wait_cnt++;
    if (vreq) begin
      vreq_cnt++;
      if (req_age == ack_delay) begin
        vack = 1'b1;
        vq   = vq_val;
        if (n_acc < 64) begin
          log_va[n_acc] = va;
          log_vd[n_acc] = vd;
          log_we[n_acc] = vwe;
        end
        n_acc++;
        req_age = 0;
      end else begin
        vack = 1'b0;
        req_age++;
      end
    end else begin
      vack    = 1'b0;
      req_age = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  int     acc_base;
  int     wait_base;
  state_e st_held;

  // One CPU cycle: strobe held for 'hold' cycles, optional mid-sequence input changes
  task automatic run_seq(input logic w, input logic [15:0] addr, input logic [7:0] data,
                         input logic dm, input int dly, input logic [7:0] rdata,
                         input int hold, input bit mutate);
    @(posedge clk); #1;
    acc_base  = n_acc;
    wait_base = wait_cnt;
    ack_delay = dly;
    vq_val    = rdata;
    a = addr; d = data; dam = dm; gram_cs = 1'b1;
    wr = w; rd = ~w;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (mutate && i == 2) begin
        dam = ~dam; a = 16'hC000; d = 8'h11;
      end
      if (mutate && i == 5) dam = ~dam;
    end
    st_held = dut.state;
    wr = 1'b0; rd = 1'b0; gram_cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a = 16'h0; d = 8'h0; wr = 1'b0; rd = 1'b0; gram_cs = 1'b0; dam = 1'b0;
    vack = 1'b0; vq = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait", 32'(wait_o), 32'd0);
    check("rst_vreq", 32'(vreq), 32'd0);
    check("rst_va",   32'(va), 32'd0);
    check("rst_dq",   32'(dq), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Normal write, immediate ack
    run_seq(1'b1, 16'h8123, 8'h05, 1'b0, 0, 8'h00, 8, 1'b0);
    check("nw_count", 32'(n_acc - acc_base), 32'd1);
    check("nw_va",    32'(log_va[acc_base]), 32'h8123);
    check("nw_vd",    32'(log_vd[acc_base]), 32'h05);
    check("nw_we",    32'(log_we[acc_base]), 32'd1);
    check("nw_wait",  32'(wait_cnt - wait_base), 32'd2);

    // DAM write to B address, one-cycle-late ack: R then G
    run_seq(1'b1, 16'h4010, 8'hA5, 1'b1, 1, 8'h00, 8, 1'b0);
    check("d1_count", 32'(n_acc - acc_base), 32'd2);
    check("d1_va0",   32'(log_va[acc_base]), 32'h8010);
    check("d1_va1",   32'(log_va[acc_base+1]), 32'hC010);
    check("d1_vd0",   32'(log_vd[acc_base]), 32'hA5);
    check("d1_vd1",   32'(log_vd[acc_base+1]), 32'hA5);
    check("d1_wait",  32'(wait_cnt - wait_base), 32'd5);

    // DAM write to G address: B then R, no G
    run_seq(1'b1, 16'hC7FF, 8'h3C, 1'b1, 0, 8'h00, 8, 1'b0);
    check("d3_count", 32'(n_acc - acc_base), 32'd2);
    check("d3_va0",   32'(log_va[acc_base]), 32'h47FF);
    check("d3_va1",   32'(log_va[acc_base+1]), 32'h87FF);
    check("d3_we1",   32'(log_we[acc_base+1]), 32'd1);
    check("d3_wait",  32'(wait_cnt - wait_base), 32'd3);
    check("d3_dq",    32'(dq), 32'h00);

    // Read ignores DAM: single G read
    run_seq(1'b0, 16'hC000, 8'h00, 1'b1, 0, 8'h81, 8, 1'b0);
    check("rd_count", 32'(n_acc - acc_base), 32'd1);
    check("rd_va",    32'(log_va[acc_base]), 32'hC000);
    check("rd_we",    32'(log_we[acc_base]), 32'd0);
    check("rd_dq",    32'(dq), 32'h81);
    check("rd_wait",  32'(wait_cnt - wait_base), 32'd2);

    // Long strobe, inputs changing mid-sequence
    run_seq(1'b1, 16'h4123, 8'h77, 1'b0, 0, 8'h00, 10, 1'b1);
    check("ls_count", 32'(n_acc - acc_base), 32'd1);
    check("ls_va",    32'(log_va[acc_base]), 32'h4123);
    check("ls_vd",    32'(log_vd[acc_base]), 32'h77);
    check("ls_held",  32'(st_held), 32'(HOLD));
    check("ls_idle",  32'(dut.state), 32'(IDLE));
    check("ls_dq",    32'(dq), 32'h81);

    // Plane 0 address is not a VRAM access
    run_seq(1'b1, 16'h0123, 8'h99, 1'b0, 0, 8'h00, 4, 1'b0);
    check("p0_count", 32'(n_acc - acc_base), 32'd0);
    check("p0_wait",  32'(wait_cnt - wait_base), 32'd0);

    // Reset during the second DAM write
    @(posedge clk); #1;
    acc_base  = n_acc;
    ack_delay = 3;
    a = 16'h4010; d = 8'h5A; dam = 1'b1; gram_cs = 1'b1; wr = 1'b1;
    for (int i = 0; i < 20 && n_acc == acc_base; i++) @(posedge clk);
    check("ra_acc1_seen", 32'(n_acc - acc_base), 32'd1);
    @(posedge clk); #1;
    check("ra_in_acc2", 32'(dut.state), 32'(ACC2));
    rst_n = 1'b0;
    wr = 1'b0; gram_cs = 1'b0;
    @(negedge clk);
    check("ra_vreq", 32'(vreq), 32'd0);
    check("ra_wait", 32'(wait_o), 32'd0);
    check("ra_va",   32'(va), 32'd0);
    check("ra_vd",   32'(vd), 32'd0);
    check("ra_dq",   32'(dq), 32'd0);
    check("ra_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    vreq_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    check("ra_no_req", 32'(vreq_cnt), 32'd0);
    check("ra_count",  32'(n_acc - acc_base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
